// File: rtl/tns_dec_seq_pkg.sv
// Shared definitions for the sequential Tribonacci-numeral-system decoder.
//   tns_weight(i) : 64-bit Tribonacci weight T(i), T(0..2) = 1, 2, 4
//   tns_sum(w)    : sum of T(0..w-1), the largest value a w-bit codeword decodes to
//   tns_blen(n)   : accumulator width for n 3-bit groups
//   tns_state_t   : decoder FSM states
package tns_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} tns_state_t;

    function automatic logic [63:0] tns_weight(input int i);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] n;
        a = 64'd1;
        b = 64'd2;
        c = 64'd4;
        if (i == 0) return a;
        if (i == 1) return b;
        for (int k = 3; k <= i; k++) begin
            n = a + b + c;
            a = b;
            b = c;
            c = n;
        end
        return c;
    endfunction

    function automatic logic [63:0] tns_sum(input int w);
        logic [63:0] s;
        s = 64'd0;
        for (int k = 0; k < w; k++) begin
            s = s + tns_weight(k);
        end
        return s;
    endfunction

    function automatic int tns_blen(input int ngroup);
        return $clog2(tns_sum(3 * ngroup) + 64'd1);
    endfunction

endpackage

// File: rtl/tns_dec_seq_if.sv
// Handshake bundle between a codeword source, the TNS decoder and the data sink.
//   in_valid/in_ready/codein    : codeword side (source drives valid and data)
//   out_valid/out_ready/dataout : result side (sink drives ready)
// master = source/sink testbench or link side, slave = decoder.
interface tns_dec_seq_if #(
    parameter int NGROUP = 8
);
    import tns_pkg::*;

    localparam int W    = 3 * NGROUP;
    localparam int BLEN = tns_blen(NGROUP);

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    codein;
    logic            out_valid;
    logic            out_ready;
    logic [BLEN-1:0] dataout;

    modport master (
        output in_valid, codein, out_ready,
        input  in_ready, out_valid, dataout
    );

    modport slave (
        input  in_valid, codein, out_ready,
        output in_ready, out_valid, dataout
    );

endinterface

// File: rtl/tns_dec_seq_grp_wsum.sv
// Combinational weighted sum of one 3-bit TNS group.
//   i_grp  : group bits {A, B, C}, C is the lowest codeword bit of the group
//   i_gidx : group index g; weights are T(3g+2), T(3g+1), T(3g)
//   o_sum  : BLEN-bit weighted sum
module tns_grp_wsum
    import tns_pkg::*;
#(
    parameter int NGROUP = 8,
    parameter int BLEN   = 22,
    parameter int GIW    = 3
) (
    input  logic [2:0]      i_grp,
    input  logic [GIW-1:0]  i_gidx,
    output logic [BLEN-1:0] o_sum
);

    logic [BLEN-1:0] w_tab_a [NGROUP];
    logic [BLEN-1:0] w_tab_b [NGROUP];
    logic [BLEN-1:0] w_tab_c [NGROUP];
    logic [BLEN-1:0] w_wa;
    logic [BLEN-1:0] w_wb;
    logic [BLEN-1:0] w_wc;

    // Constant weight table, one row per group; truncation to BLEN is lossless
    // because BLEN holds the sum of all weights.
    for (genvar g = 0; g < NGROUP; g++) begin : g_tab
        localparam logic [63:0] WA = tns_weight(3 * g + 2);
        localparam logic [63:0] WB = tns_weight(3 * g + 1);
        localparam logic [63:0] WC = tns_weight(3 * g);
        assign w_tab_a[g] = WA[BLEN-1:0];
        assign w_tab_b[g] = WB[BLEN-1:0];
        assign w_tab_c[g] = WC[BLEN-1:0];
    end

    always_comb begin
        w_wa = '0;
        w_wb = '0;
        w_wc = '0;
        for (int g = 0; g < NGROUP; g++) begin
            if (i_gidx == GIW'(g)) begin
                w_wa = w_tab_a[g];
                w_wb = w_tab_b[g];
                w_wc = w_tab_c[g];
            end
        end
    end

    assign o_sum = ({BLEN{i_grp[2]}} & w_wa)
                 + ({BLEN{i_grp[1]}} & w_wb)
                 + ({BLEN{i_grp[0]}} & w_wc);

endmodule

// File: rtl/tns_dec_seq.sv
// Multi-cycle TNS decoder: converts a 3*NGROUP-bit Tribonacci codeword to binary,
// GPC groups per clock, LSB group first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : tns_dec_seq_if.slave (codeword in, binary result out, valid/ready both sides)
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a codeword
//   BUSY  | accumulating GPC groups per cycle for L = NGROUP/GPC cycles
//   DONE  | out_valid high, result held until out_ready
module tns_dec_seq
    import tns_pkg::*;
#(
    parameter int NGROUP = 8,
    parameter int GPC    = 1
) (
    input  logic           clk,
    input  logic           rst,
    tns_dec_seq_if.slave   bus
);

    localparam int W    = 3 * NGROUP;
    localparam int BLEN = tns_blen(NGROUP);
    localparam int L    = NGROUP / GPC;
    localparam int CW   = (L > 1) ? $clog2(L) : 1;
    localparam int GIW  = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    if (NGROUP < 1 || NGROUP > 16) begin : g_bad_ngroup
        $error("tns_dec_seq: NGROUP must be 1..16");
    end
    if (GPC < 1 || (NGROUP % GPC) != 0) begin : g_bad_gpc
        $error("tns_dec_seq: GPC must divide NGROUP");
    end

    tns_state_t      r_state;
    logic [W-1:0]    r_sreg;
    logic [BLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [GIW-1:0]  w_gidx [GPC];
    logic [BLEN-1:0] w_gsum [GPC];
    logic [BLEN-1:0] w_step;

    for (genvar j = 0; j < GPC; j++) begin : g_grp
        assign w_gidx[j] = GIW'(int'(r_cnt) * GPC + j);

        tns_grp_wsum #(
            .NGROUP (NGROUP),
            .BLEN   (BLEN),
            .GIW    (GIW)
        ) u_wsum (
            .i_grp  (r_sreg[3*j +: 3]),
            .i_gidx (w_gidx[j]),
            .o_sum  (w_gsum[j])
        );
    end

    always_comb begin
        w_step = '0;
        for (int j = 0; j < GPC; j++) begin
            w_step = w_step + w_gsum[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // r_in_ready is low for one cycle after reset, so a
                    // codeword is only taken once in_ready has been shown.
                    if (bus.in_valid && r_in_ready) begin
                        r_sreg     <= bus.codein;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    r_acc  <= r_acc + w_step;
                    r_sreg <= r_sreg >> (3 * GPC);
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(L - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Return through IDLE so a new codeword never lands on
                    // the same edge as the result handshake.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dataout   = r_acc;

endmodule

// File: tb/tb_tns_dec_seq.sv
module tb_tns_dec_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] codein;

    int n_checks = 0;
    int n_fail   = 0;

    tns_dec_seq_if #(.NGROUP(8)) if_a ();
    tns_dec_seq_if #(.NGROUP(8)) if_b ();
    tns_dec_seq_if #(.NGROUP(8)) if_c ();
    tns_dec_seq_if #(.NGROUP(1)) if_d ();

    tns_dec_seq #(.NGROUP(8), .GPC(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    tns_dec_seq #(.NGROUP(8), .GPC(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    tns_dec_seq #(.NGROUP(8), .GPC(4)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    tns_dec_seq #(.NGROUP(1), .GPC(1)) u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    assign if_a.in_valid = in_valid;  assign if_a.out_ready = out_ready;  assign if_a.codein = codein;
    assign if_b.in_valid = in_valid;  assign if_b.out_ready = out_ready;  assign if_b.codein = codein;
    assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;  assign if_c.codein = codein;
    assign if_d.in_valid = in_valid;  assign if_d.out_ready = out_ready;  assign if_d.codein = codein[2:0];

    logic        ir   [4];
    logic        ov   [4];
    logic [21:0] dout [4];

    assign ir[0] = if_a.in_ready;   assign ov[0] = if_a.out_valid;  assign dout[0] = if_a.dataout;
    assign ir[1] = if_b.in_ready;   assign ov[1] = if_b.out_valid;  assign dout[1] = if_b.dataout;
    assign ir[2] = if_c.in_ready;   assign ov[2] = if_c.out_valid;  assign dout[2] = if_c.dataout;
    assign ir[3] = if_d.in_ready;   assign ov[3] = if_d.out_valid;  assign dout[3] = {19'd0, if_d.dataout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] cw;
        longint      exp8;
        longint      exp1;
    } vec_t;

    vec_t vecs [10];
    int   lat_exp [4] = '{8, 4, 2, 1};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: Tribonacci weights rebuilt from the recurrence.
    function automatic longint ref_dec(input logic [23:0] cw, input int nbits);
        longint t [24];
        longint s;
        t[0] = 1; t[1] = 2; t[2] = 4;
        for (int i = 3; i < 24; i++) t[i] = t[i-1] + t[i-2] + t[i-3];
        s = 0;
        for (int i = 0; i < nbits; i++) if (cw[i]) s += t[i];
        return s;
    endfunction

    // Feed one codeword to all four decoders and check value and latency of each.
    task automatic run_word(input logic [23:0] cw, input longint exp8, input longint exp1);
        int          lat  [4];
        bit          seen [4];
        longint      got  [4];
        int          w;
        w = 0;
        while (!(ir[0] && ir[1] && ir[2] && ir[3]) && w < 40) begin
            @(posedge clk); #1; w++;
        end
        check("ready_before_word", longint'(ir[0] && ir[1] && ir[2] && ir[3]), 1);
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0; lat[d] = -1; got[d] = -1;
        end
        codein    = cw;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1; lat[d] = c; got[d] = longint'(dout[d]);
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("latency_d%0d_cw%06h", d, cw), lat[d], lat_exp[d]);
            check($sformatf("dataout_d%0d_cw%06h", d, cw), got[d], (d == 3) ? exp1 : exp8);
        end
    endtask

    initial begin
        logic [23:0] rcw;
        int          w;
        int          npulse;
        int          first_c;
        int          second_c;

        vecs[0] = '{24'hFFFFFF, 3045152, 7};
        vecs[1] = '{24'h000001, 1,       1};
        vecs[2] = '{24'h800000, 1389537, 0};
        vecs[3] = '{24'h000008, 7,       0};
        vecs[4] = '{24'h000007, 7,       7};
        vecs[5] = '{24'h000002, 2,       2};
        vecs[6] = '{24'h000004, 4,       4};
        vecs[7] = '{24'h000010, 13,      0};
        vecs[8] = '{24'h000030, 37,      0};
        vecs[9] = '{24'h000005, 5,       5};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codein = '0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_in_ready",  longint'(ir[0]), 0);
        check("reset_out_valid", longint'(ov[0]), 0);
        check("reset_dataout",   longint'(dout[0]), 0);
        check("reset_in_ready_d3", longint'(ir[3]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_in_ready", longint'(ir[0]), 1);

        // Directed table
        for (int v = 0; v < 10; v++) begin
            run_word(vecs[v].cw, vecs[v].exp8, vecs[v].exp1);
        end

        // Random codewords against the reference sum
        for (int r = 0; r < 6; r++) begin
            rcw = 24'($urandom);
            run_word(rcw, ref_dec(rcw, 24), ref_dec(rcw, 3));
        end

        // Backpressure: result held in DONE, in_valid ignored
        codein = 24'hFFFFFF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        codein = 24'h000001;
        w = 0;
        while (!ov[0] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("bp_valid_rise", longint'(ov[0]), 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_out_valid_c%0d", c), longint'(ov[0]), 1);
            check($sformatf("bp_dataout_c%0d", c), longint'(dout[0]), 3045152);
            check($sformatf("bp_in_ready_c%0d", c), longint'(ir[0]), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", longint'(ov[0]), 0);
        check("bp_release_in_ready",  longint'(ir[0]), 1);
        repeat (12) @(posedge clk);
        #1;

        // Reset during BUSY (third BUSY cycle of the GPC=1 decoder)
        codein = 24'hFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", longint'(ov[0]), 0);
        check("midrst_dataout",   longint'(dout[0]), 0);
        check("midrst_in_ready",  longint'(ir[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_again", longint'(ir[0]), 1);
        run_word(24'h000007, 7, 7);

        // Back-to-back streaming on the NGROUP=1 decoder
        codein = 24'h000007; in_valid = 1'b1; out_ready = 1'b1;
        npulse = 0; first_c = -1; second_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov[3]) begin
                if (npulse == 0) first_c = c;
                if (npulse == 1) second_c = c;
                npulse++;
            end
        end
        in_valid = 1'b0;
        check("stream_pulses", npulse, 3);
        check("stream_first", first_c, 1);
        check("stream_period", second_c - first_c, 3);
        repeat (20) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tns_dec_seq.md
# tns_dec_seq

Parametrised, multi-cycle Tribonacci-numeral-system (TNS) decoder for the 3C1S crosstalk-avoidance code path. It converts an N-bit TNS codeword into its binary value, processing GPC 3-bit groups per clock, LSB group first. The block has valid/ready handshakes on both sides and sits on the receive side of a CAC link, after the code-word register and before the data sink. It is the generalised, sequential successor to the fixed 24-bit combinational TNS decoder.

## Interface
- NGROUP, 8: number of 3-bit code groups; codeword width W = 3*NGROUP; legal range 1..16.
- GPC, 1: groups decoded per clock; must divide NGROUP (elaboration error otherwise).
- BLEN, derived (localparam, not overridable): $clog2(tns_sum(W)+1); 22 for NGROUP=8.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword.
- codein  in  W  TNS codeword; bit i carries weight T(i).
- out_valid  out  1  dataout holds a finished result.
- out_ready  in  1  sink accepts the result.
- dataout  out  BLEN  binary value sum(codein[i]*T(i)).

## Operation
- Weights: T(0)=1, T(1)=2, T(2)=4, T(i)=T(i-1)+T(i-2)+T(i-3). Group g uses bits 3g+2..3g, weights T(3g+2), T(3g+1), T(3g) (A, B, C).
- The FSM has three states: IDLE, BUSY, DONE. The reset state is IDLE.
- IDLE: in_ready=1. When in_valid is high, the decoder captures codein into shift register sreg, clears acc and cnt, and goes to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle does the following:
  - acc += weighted sum of the low GPC groups of sreg, using the group index cnt*GPC+j.
  - sreg shifts right by 3*GPC.
  - cnt increments.
  - When cnt==L-1, with L=NGROUP/GPC, the next state is DONE.
- DONE: out_valid=1 and dataout=acc, both held stable while out_ready is low. When out_ready is high, the next state is IDLE.
- A new codeword is not accepted in the same cycle as the output handshake.
- Arithmetic: acc is BLEN bits wide. The sum of all weights fits by construction, so there is no overflow or saturation logic. Weights are unsigned constants, truncated to BLEN.
- Any codein value is decoded arithmetically. Codeword validity (3C1S legality) is not checked here.
- in_valid while the decoder is busy or done is ignored; the sender holds it until in_ready.
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after reset. out_valid=0, dataout=0, acc=0, cnt=0.
- Reset mid-operation, in BUSY or DONE, drops the current codeword silently. No partial result appears.

## Timing
- L = NGROUP/GPC.
- Input accepted at edge k. out_valid rises after edge k+L, so latency is L cycles.
- Maximum throughput is one codeword per L+2 cycles: accept, L BUSY cycles, DONE, back to IDLE.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.
- The critical path is one GPC-group weighted add (3*GPC constant-weight terms) plus the BLEN-bit accumulate.

## Structure
- Package tns_pkg holds:
  - function tns_weight(i), returning 64-bit T(i);
  - function tns_sum(w), the sum of T(0..w-1);
  - enum tns_state_t {IDLE, BUSY, DONE}.
- Sub-module tns_grp_wsum (combinational) takes a 3-bit group and a group index and returns the BLEN-bit weighted sum. The top instantiates it GPC times.

## Test plan
- NGROUP=8, GPC=1, codein=24'hFFFFFF, out_ready=1: dataout=3045152, with out_valid asserted exactly 8 cycles after acceptance.
- NGROUP=8, GPC=1, single-bit codewords:
  - codein=24'h000001 gives dataout=1;
  - codein=24'h800000 gives 1389537;
  - codein=24'h000008 gives 7.
- NGROUP=8, GPC=2 and GPC=4, codein=24'hFFFFFF: dataout=3045152 with latency 4 and 2 respectively. Random codewords match a reference weighted sum.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. dataout and out_valid must stay stable, and in_ready must stay 0 despite in_valid=1.
- Assert rst during BUSY (cycle 3 of 8): the next cycle is IDLE with out_valid=0 and dataout=0. The next codeword 24'h000007 decodes to 7.
- NGROUP=1, GPC=1, codein=3'b111: dataout=7, latency 1, BLEN=3. Back-to-back streaming shows one result per 3 cycles.
